// File: rtl/rotenc_pkg.sv
// Shared definitions for the rotary hex switch controller.
// FSM state constants, code width, the ambiguous-step delta and the modulo
// delta helper used when classifying a committed change.

package rotenc_pkg;

  // Width of the rotary switch code.
  localparam int unsigned CODE_W = 4;

  // Controller states.
  typedef logic [1:0] state_t;
  localparam state_t ST_INIT   = 2'd0;
  localparam state_t ST_IDLE   = 2'd1;
  localparam state_t ST_SETTLE = 2'd2;
  localparam state_t ST_COMMIT = 2'd3;

  // A change of exactly half a turn cannot be assigned a direction.
  localparam logic [CODE_W-1:0] AMBIG_DELTA = 4'd8;

  // Modulo-16 step from old_code to new_code; 1..7 is up, 9..15 is down.
  function automatic logic [CODE_W-1:0] rot_delta(input logic [CODE_W-1:0] old_code,
                                                  input logic [CODE_W-1:0] new_code);
    return new_code - old_code;
  endfunction

endpackage

// File: rtl/rotenc_debounce.sv
// Input synchronizer, candidate register and stability counter.
// The controller steers this block with two controls:
//   i_load  - capture the synchronized code as the new candidate, restart count
//   i_track - follow the synchronized code: reload on change, count while equal
// o_stable_new pulses on the cycle the candidate has been seen DEB_CYCLES
// times in a row; the caller acts on that same clock edge.

module rotenc_debounce
  import rotenc_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 270000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] i_raw,
  input  logic              i_load,
  input  logic              i_track,
  output logic [CODE_W-1:0] o_sync,
  output logic [CODE_W-1:0] o_cand,
  output logic              o_stable_new
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(DEB_CYCLES - 2);

  logic [CODE_W-1:0] r_sync [SYNC_STAGES];
  logic [CODE_W-1:0] r_cand;
  logic [CNT_W-1:0]  r_cnt;
  logic [CODE_W-1:0] w_s;
  logic              w_match;

  assign w_s     = r_sync[SYNC_STAGES-1];
  assign w_match = (w_s == r_cand);

  // Synchronizer chain for the asynchronous switch pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= i_raw;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  // Candidate capture and stability counting; the counter saturates at its
  // last value so a long-stable input produces a single pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cand <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_cand <= w_s;
      r_cnt  <= '0;
    end else if (i_track) begin
      if (!w_match) begin
        r_cand <= w_s;
        r_cnt  <= '0;
      end else if (r_cnt != CNT_LAST) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Pulse on the edge where the counter steps onto its last value.
  always_comb begin
    o_stable_new = i_track && !i_load && w_match && (r_cnt == CNT_PRE);
  end

  assign o_sync = w_s;
  assign o_cand = r_cand;

endmodule

// File: rtl/rotenc_ctrl.sv
// Rotary hex switch sequencing controller.
// Debounces the 4-bit switch code, classifies each committed change as up,
// down or ambiguous (half-turn), accumulates an 8-bit position and drives the
// LED mirror and the two hex digit codes.
// Build option: define ROTENC_DP_EN to enable the decimal-point hold timer;
// otherwise dp is tied low and no timer logic exists.

module rotenc_ctrl
  import rotenc_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 270000,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DP_HOLD     = 2700000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] prrot,
  output logic [3:0] prled,
  output logic [3:0] code,
  output logic [7:0] pos,
  output logic       chg,
  output logic       dir,
  output logic       err,
  output logic [4:0] dig0,
  output logic [4:0] dig1,
  output logic       dp
);

  if (DEB_CYCLES < 2 || DEB_CYCLES > 24'hFF_FFFF) begin : g_bad_deb
    $error("DEB_CYCLES out of range");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (DP_HOLD == 0) begin : g_bad_hold
    $error("DP_HOLD must be nonzero");
  end

  state_t            r_state;
  logic [CODE_W-1:0] r_code;
  logic [7:0]        r_pos;
  logic              r_dir;
  logic              r_chg;
  logic              r_err;

  logic [CODE_W-1:0] w_s;
  logic [CODE_W-1:0] w_cand;
  logic              w_stable_new;
  logic              w_load;
  logic              w_track;
  logic [CODE_W-1:0] w_delta;
  logic              w_commit;

  rotenc_debounce #(
    .DEB_CYCLES  (DEB_CYCLES),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_debounce (
    .clk          (clk),
    .rst          (rst),
    .i_raw        (prrot),
    .i_load       (w_load),
    .i_track      (w_track),
    .o_sync       (w_s),
    .o_cand       (w_cand),
    .o_stable_new (w_stable_new)
  );

  // Debouncer steering: IDLE starts a settle on any departure from the
  // committed code; INIT and SETTLE follow the input, except that a return
  // to the committed code in SETTLE aborts the settle instead of counting.
  always_comb begin
    w_load   = (r_state == ST_IDLE) && (w_s != r_code);
    w_track  = (r_state == ST_INIT) || ((r_state == ST_SETTLE) && (w_s != r_code));
    w_delta  = rot_delta(r_code, w_cand);
    w_commit = (r_state == ST_COMMIT);
  end

  // Controller FSM, commit classification and position arithmetic.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_code  <= '0;
      r_pos   <= '0;
      r_dir   <= 1'b0;
      r_chg   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_chg <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        ST_INIT: begin
          // First stable value only establishes the reference code.
          if (w_stable_new) begin
            r_code  <= w_cand;
            r_pos   <= '0;
            r_state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (w_load) begin
            r_state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (w_s == r_code) begin
            r_state <= ST_IDLE;
          end else if (w_stable_new) begin
            r_state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          r_code  <= w_cand;
          r_chg   <= 1'b1;
          r_state <= ST_IDLE;
          if (w_delta == AMBIG_DELTA) begin
            r_err <= 1'b1;
          end else if (!w_delta[3]) begin
            r_pos <= r_pos + {4'd0, w_delta};
            r_dir <= 1'b1;
          end else begin
            r_pos <= r_pos - (8'd16 - {4'd0, w_delta});
            r_dir <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end

`ifdef ROTENC_DP_EN
  // Wide enough for both the hold value and the blink tap at bit 20.
  localparam int unsigned DP_W = ($clog2(DP_HOLD + 1) > 21) ? $clog2(DP_HOLD + 1) : 21;

  logic [DP_W-1:0] r_dp_cnt;
  logic            r_dp_blink;

  // Decimal-point hold timer, retriggered by every committed change.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dp_cnt   <= '0;
      r_dp_blink <= 1'b0;
    end else if (w_commit) begin
      r_dp_cnt   <= DP_W'(DP_HOLD);
      r_dp_blink <= (w_delta == AMBIG_DELTA);
    end else if (r_dp_cnt != '0) begin
      r_dp_cnt <= r_dp_cnt - DP_W'(1);
    end
  end

  // Ambiguous changes blink the point instead of holding it steady.
  always_comb begin
    dp = r_dp_blink ? r_dp_cnt[20] : (r_dp_cnt != '0);
  end
`else
  logic w_commit_unused;
  assign w_commit_unused = w_commit;
  assign dp = 1'b0;
`endif

  assign prled = r_code;
  assign code  = r_code;
  assign pos   = r_pos;
  assign chg   = r_chg;
  assign dir   = r_dir;
  assign err   = r_err;
  assign dig0  = {1'b0, r_code};
  assign dig1  = {1'b0, r_pos[3:0]};

endmodule

// File: tb/tb_rotenc_ctrl.sv
// Testbench for rotenc_ctrl: directed scenarios followed by randomized
// switch activity, checked every cycle against a behavioural model built on
// run lengths of the synchronized input.

module tb_rotenc_ctrl;

  localparam int unsigned DEB  = 4;
  localparam int unsigned SYNC = 2;
  localparam int unsigned HOLD = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] prrot;
  logic [3:0] prled;
  logic [3:0] code;
  logic [7:0] pos;
  logic       chg;
  logic       dir;
  logic       err;
  logic [4:0] dig0;
  logic [4:0] dig1;
  logic       dp;

  always #5 clk = ~clk;

  rotenc_ctrl #(
    .DEB_CYCLES  (DEB),
    .SYNC_STAGES (SYNC),
    .DP_HOLD     (HOLD)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .prrot (prrot),
    .prled (prled),
    .code  (code),
    .pos   (pos),
    .chg   (chg),
    .dir   (dir),
    .err   (err),
    .dig0  (dig0),
    .dig1  (dig1),
    .dp    (dp)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state.
  logic [3:0] m_sync [SYNC];
  logic [3:0] m_val;
  logic [3:0] m_cand;
  logic [3:0] m_code;
  logic [7:0] m_pos;
  int         m_run;
  bit         m_init;
  bit         m_pend;
  bit         m_dir;
  bit         m_chg;
  bit         m_err;
  int         m_dpcnt;
  bit         m_blink;

  // One clock edge of the reference: m_run counts consecutive identical
  // synchronized samples away from the committed code; DEB of them schedule a
  // commit, which takes effect (and is visible) on the following edge.
  task automatic model_edge(input bit r, input logic [3:0] raw);
    logic [3:0] s;
    logic [3:0] d;
    if (r) begin
      for (int i = 0; i < SYNC; i++) m_sync[i] = 4'h0;
      m_val = 4'h0; m_run = 1; m_init = 1; m_pend = 0; m_cand = 4'h0;
      m_code = 4'h0; m_pos = 8'h00; m_dir = 0; m_chg = 0; m_err = 0;
      m_dpcnt = 0; m_blink = 0;
    end else begin
      s = m_sync[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = raw;
      m_chg = 0;
      m_err = 0;
      if (m_pend) begin
        d = m_cand - m_code;
        m_chg = 1;
        if (d == 4'd8) begin
          m_err = 1;
        end else if (d < 4'd8) begin
          m_pos = m_pos + 8'(d);
          m_dir = 1;
        end else begin
          m_pos = m_pos - 8'(16 - int'(d));
          m_dir = 0;
        end
        m_code  = m_cand;
        m_pend  = 0;
        m_run   = 0;
        m_dpcnt = HOLD;
        m_blink = (d == 4'd8);
      end else begin
        if (m_dpcnt != 0) m_dpcnt--;
        if (m_init) begin
          if (s == m_val) m_run++;
          else begin m_val = s; m_run = 1; end
          if (m_run == DEB) begin
            m_code = s; m_pos = 8'h00; m_init = 0; m_run = 0;
          end
        end else if (s == m_code) begin
          m_run = 0;
        end else begin
          if (m_run > 0 && s == m_val) m_run++;
          else begin m_val = s; m_run = 1; end
          if (m_run == DEB) begin
            m_pend = 1; m_cand = s;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    logic exp_dp;
`ifdef ROTENC_DP_EN
    exp_dp = m_blink ? 1'(m_dpcnt >> 20) : (m_dpcnt != 0);
`else
    exp_dp = 1'b0;
`endif
    check("chg",   chg,   m_chg);
    check("err",   err,   m_err);
    check("dir",   dir,   m_dir);
    check("pos",   pos,   m_pos);
    check("code",  code,  m_code);
    check("prled", prled, m_code);
    check("dig0",  dig0,  {1'b0, m_code});
    check("dig1",  dig1,  {1'b0, m_pos[3:0]});
    check("dp",    dp,    exp_dp);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(rst, prrot);
    #1;
    compare_all();
  endtask

  task automatic hold(input logic [3:0] v, input int n);
    prrot = v;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int lat;
    bit got;

    rst   = 1'b1;
    prrot = 4'h5;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b0;
    hold(4'h5, 15);

    // Single step up with explicit latency measurement.
    prrot = 4'h6;
    lat = 0;
    got = 0;
    for (int k = 1; k <= 20 && !got; k++) begin
      step();
      if (chg) begin
        got = 1;
        lat = k;
      end
    end
    check("latency", lat, SYNC + DEB + 1);
    hold(4'h6, 12);

    // Wrap-around in both directions.
    hold(4'h0, 12);
    hold(4'hF, 12);
    hold(4'h0, 12);

    // Bounce, then settle; then a short excursion back to the old code.
    hold(4'h6, 12);
    for (int i = 0; i < 2; i++) begin
      hold(4'h7, 2);
      hold(4'h6, 2);
    end
    hold(4'h7, 12);
    hold(4'h6, 2);
    hold(4'h7, 12);

    // Ambiguous half-turn and multi-step.
    hold(4'h2, 12);
    hold(4'hA, 12);
    hold(4'h2, 12);
    hold(4'h5, 12);

    // Retrigger of the decimal-point hold.
    hold(4'h3, 5);
    hold(4'h4, 14);

    // Reset in the middle of a settle.
    hold(4'h9, 4);
    rst = 1'b1;
    hold(4'h9, 1);
    rst = 1'b0;
    hold(4'h9, 12);

    // Randomized switch activity with occasional resets.
    for (int seg = 0; seg < 400; seg++) begin
      if ($urandom_range(49) == 0) begin
        rst = 1'b1;
        hold(4'($urandom_range(15)), int'($urandom_range(1, 2)));
        rst = 1'b0;
      end
      hold(4'($urandom_range(15)), int'($urandom_range(1, 10)));
    end
    hold(4'h1, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
